// File: rtl/alu4_flow_checker.sv
// rtl/alu4_flow_checker.sv - exhaustive stimulus/response checker for the 4-bit flow-demo ALU
module alu4_flow_checker #(
    parameter int SETTLE       = 1,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  dut_a,
    output logic [3:0]  dut_b,
    output logic [1:0]  dut_op,
    input  logic [3:0]  dut_y,
    input  logic        dut_cout,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [10:0] err_count,
    output logic        fail_seen,
    output logic [9:0]  fail_vec
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam bit         STOP_EN     = (STOP_ON_FAIL != 0);

    state_t      state_q, state_d;
    logic [9:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [10:0] err_q, err_d;
    logic        fseen_q, fseen_d;
    logic [9:0]  fvec_q, fvec_d;

    logic [3:0]  exp_y;
    logic        exp_c;
    logic        mismatch;
    logic        sample;

    // Golden ALU evaluated on the vector currently on the pins (idx_q drives them).
    assign exp_y    = (idx_q[3:0] & idx_q[7:4]) ^ {4{idx_q[8]}};
    assign exp_c    = (idx_q[3] | idx_q[7]) ^ idx_q[9];
    assign mismatch = (dut_y != exp_y) || (dut_cout != exp_c);
    assign sample   = (state_q == S_RUN) && (cnt_q == SETTLE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fseen_q <= 1'b0;
            fvec_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fseen_q <= fseen_d;
            fvec_q  <= fvec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fseen_d = fseen_q;
        fvec_d  = fvec_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    fseen_d = 1'b0;
                    fvec_d  = '0;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 4'd1;
                if (sample) begin
                    if (mismatch) begin
                        err_d = err_q + 11'd1;
                        if (!fseen_q) begin
                            fseen_d = 1'b1;
                            fvec_d  = idx_q;
                        end
                    end
                    // Operands stay on the last vector once the sweep ends.
                    if ((idx_q == 10'd1023) || (STOP_EN && mismatch)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 10'd1;
                        cnt_d = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dut_a     = idx_q[3:0];
    assign dut_b     = idx_q[7:4];
    assign dut_op    = idx_q[9:8];
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign pass      = done && (err_q == 11'd0);
    assign err_count = err_q;
    assign fail_seen = fseen_q;
    assign fail_vec  = fvec_q;

endmodule

// File: tb/tb_alu4_flow_checker.sv
// tb/tb_alu4_flow_checker.sv - scoreboard bench for alu4_flow_checker
module tb_alu4_flow_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst_c, start0, start1, start2;
    logic [3:0]  a0, b0, y0, a1, b1, y1, a2, b2, y2;
    logic [1:0]  op0, op1, op2;
    logic        c0, c1, c2;
    logic        busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
    logic [10:0] err0, err1, err2;
    logic        fs0, fs1, fs2;
    logic [9:0]  fv0, fv1, fv2;

    int mode;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int err; int fs; int fv; int ps; int cyc; int a; int b; int op;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    function automatic logic [4:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        return {(a[3] | b[3]) ^ op[1], (a & b) ^ {4{op[0]}}};
    endfunction

    // ALU models: u0 selectable fault, u1 y[2] stuck-at-0, u2 output registered one cycle.
    logic [4:0] g0, g1, r0, r2;
    assign g0 = alu(a0, b0, op0);
    assign g1 = alu(a1, b1, op1);
    always @(posedge clk) begin
        r0 <= g0;
        r2 <= alu(a2, b2, op2);
    end
    always_comb begin
        y0 = g0[3:0];
        c0 = g0[4];
        case (mode)
            1: y0 = g0[3:0] & 4'b1011;
            2: c0 = ~g0[4];
            3: begin y0 = r0[3:0]; c0 = r0[4]; end
            default: ;
        endcase
    end
    assign y1 = g1[3:0] & 4'b1011;
    assign c1 = g1[4];
    assign y2 = r2[3:0];
    assign c2 = r2[4];

    alu4_flow_checker #(.SETTLE(1), .STOP_ON_FAIL(0)) u0 (
        .clk(clk), .rst(rst0), .start(start0), .dut_a(a0), .dut_b(b0), .dut_op(op0),
        .dut_y(y0), .dut_cout(c0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_seen(fs0), .fail_vec(fv0));

    alu4_flow_checker #(.SETTLE(1), .STOP_ON_FAIL(1)) u1 (
        .clk(clk), .rst(rst_c), .start(start1), .dut_a(a1), .dut_b(b1), .dut_op(op1),
        .dut_y(y1), .dut_cout(c1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_seen(fs1), .fail_vec(fv1));

    alu4_flow_checker #(.SETTLE(3), .STOP_ON_FAIL(0)) u2 (
        .clk(clk), .rst(rst_c), .start(start2), .dut_a(a2), .dut_b(b2), .dut_op(op2),
        .dut_y(y2), .dut_cout(c2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_seen(fs2), .fail_vec(fv2));

    task automatic chk(input string name, input int act, input int exp);
        if (exp >= 0) begin
            total++;
            if (act != exp) begin
                bad++;
                $display("FAIL %s: got %0d expected %0d", name, act, exp);
            end
        end
    endtask

    task automatic check_run(input string tag, input exp_t e, input int err, input int fs,
                             input int fv, input int ps, input int cyc, input int a,
                             input int b, input int op);
        chk({tag, " err_count"}, err, e.err);
        chk({tag, " fail_seen"}, fs, e.fs);
        chk({tag, " fail_vec"}, fv, e.fv);
        chk({tag, " pass"}, ps, e.ps);
        chk({tag, " busy_cycles"}, cyc, e.cyc);
        chk({tag, " dut_a"}, a, e.a);
        chk({tag, " dut_b"}, b, e.b);
        chk({tag, " dut_op"}, op, e.op);
    endtask

    // Monitors: count busy cycles, pop and compare on each rising done.
    int cnt0 = 0, cnt1 = 0, cnt2 = 0;
    logic pd0 = 1'b0, pd1 = 1'b0, pd2 = 1'b0;
    exp_t e0, e1, e2;

    initial forever begin
        @(negedge clk);
        if (rst0) cnt0 = 0;
        else if (busy0) cnt0++;
        if (done0 && !pd0) begin
            if (q0.size() == 0) chk("u0 unexpected done", 1, 0);
            else begin
                e0 = q0.pop_front();
                check_run("u0", e0, int'(err0), int'(fs0), int'(fv0), int'(pass0), cnt0,
                          int'(a0), int'(b0), int'(op0));
            end
            cnt0 = 0;
        end
        pd0 = done0;
    end

    initial forever begin
        @(negedge clk);
        if (rst_c) cnt1 = 0;
        else if (busy1) cnt1++;
        if (done1 && !pd1) begin
            if (q1.size() == 0) chk("u1 unexpected done", 1, 0);
            else begin
                e1 = q1.pop_front();
                check_run("u1", e1, int'(err1), int'(fs1), int'(fv1), int'(pass1), cnt1,
                          int'(a1), int'(b1), int'(op1));
            end
            cnt1 = 0;
        end
        pd1 = done1;
    end

    initial forever begin
        @(negedge clk);
        if (rst_c) cnt2 = 0;
        else if (busy2) cnt2++;
        if (done2 && !pd2) begin
            if (q2.size() == 0) chk("u2 unexpected done", 1, 0);
            else begin
                e2 = q2.pop_front();
                check_run("u2", e2, int'(err2), int'(fs2), int'(fv2), int'(pass2), cnt2,
                          int'(a2), int'(b2), int'(op2));
            end
            cnt2 = 0;
        end
        pd2 = done2;
    end

    task automatic pulse(input int which);
        @(negedge clk);
        if (which == 0) start0 = 1'b1;
        else if (which == 1) start1 = 1'b1;
        else start2 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int budget);
        int n = 0;
        logic d;
        d = (which == 0) ? done0 : (which == 1) ? done1 : done2;
        while (!d && n < budget) begin
            @(negedge clk);
            n++;
            d = (which == 0) ? done0 : (which == 1) ? done1 : done2;
        end
        chk($sformatf("u%0d done reached", which), int'(d), 1);
        #1;
    endtask

    task automatic wait_idx0(input int target, input int budget);
        int n = 0;
        while (int'({op0, b0, a0}) != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("u0 idx reached", int'({op0, b0, a0}), target);
    endtask

    initial begin
        mode   = 0;
        rst0   = 1'b1;
        rst_c  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        #12;
        chk("reset dut_a", int'(a0), 0);
        chk("reset busy", int'(busy0), 0);
        chk("reset done", int'(done0), 0);
        chk("reset pass", int'(pass0), 0);
        chk("reset err_count", int'(err0), 0);
        @(negedge clk);
        rst0  = 1'b0;
        rst_c = 1'b0;

        // Clean sweep with an ignored start at idx 300.
        q0.push_back(exp_t'{0, 0, 0, 1, 1024, 15, 15, 3});
        pulse(0);
        wait_idx0(300, 400);
        chk("busy at idx 300", int'(busy0), 1);
        pulse(0);
        wait_done(0, 1200);

        mode = 1;
        q0.push_back(exp_t'{512, 1, 68, 0, 1024, 15, 15, 3});
        pulse(0);
        wait_done(0, 1200);

        mode = 2;
        q0.push_back(exp_t'{1024, 1, 0, 0, 1024, 15, 15, 3});
        pulse(0);
        wait_done(0, 1200);

        // Restart from DONE with a clean ALU: previous errors must be cleared.
        mode = 0;
        q0.push_back(exp_t'{0, 0, 0, 1, 1024, 15, 15, 3});
        pulse(0);
        chk("restart clears err_count", int'(err0), 0);
        chk("restart clears fail_seen", int'(fs0), 0);
        wait_done(0, 1200);

        mode = 3;
        q0.push_back(exp_t'{-1, 1, -1, 0, 1024, 15, 15, 3});
        pulse(0);
        wait_done(0, 1200);

        // Reset mid-sweep while errors are accumulating.
        mode = 2;
        pulse(0);
        wait_idx0(500, 600);
        chk("err before reset", int'(err0), 500);
        chk("fail_seen before reset", int'(fs0), 1);
        #2 rst0 = 1'b1;
        #1;
        chk("midrst dut_a", int'(a0), 0);
        chk("midrst dut_b", int'(b0), 0);
        chk("midrst dut_op", int'(op0), 0);
        chk("midrst busy", int'(busy0), 0);
        chk("midrst done", int'(done0), 0);
        chk("midrst pass", int'(pass0), 0);
        chk("midrst err_count", int'(err0), 0);
        chk("midrst fail_seen", int'(fs0), 0);
        chk("midrst fail_vec", int'(fv0), 0);
        @(negedge clk);
        #1 rst0 = 1'b0;

        mode = 0;
        q0.push_back(exp_t'{0, 0, 0, 1, 1024, 15, 15, 3});
        pulse(0);
        wait_done(0, 1200);

        // Stop-on-fail instance: first failure at vector 68 (a=4, b=4, op=0).
        q1.push_back(exp_t'{1, 1, 68, 0, 69, 4, 4, 0});
        pulse(1);
        wait_done(1, 200);
        repeat (5) @(negedge clk);
        chk("u1 done held", int'(done1), 1);
        chk("u1 dut_a held", int'(a1), 4);
        chk("u1 dut_b held", int'(b1), 4);
        chk("u1 err held", int'(err1), 1);

        // SETTLE=3 tolerates the registered ALU.
        q2.push_back(exp_t'{0, 0, 0, 1, 3072, 15, 15, 3});
        pulse(2);
        wait_done(2, 3300);

        repeat (3) @(negedge clk);
        chk("u0 queue drained", q0.size(), 0);
        chk("u1 queue drained", q1.size(), 0);
        chk("u2 queue drained", q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu4_flow_checker.md
# alu4_flow_checker

Self-checking stimulus/response driver for the 4-bit flow-demo ALU. It sweeps all 1024 combinations of `{op, b, a}` into the ALU's input pins and samples `y`/`cout` back. Each sample is compared against the golden function `y = (a & b) ^ {4{op[0]}}`, `cout = (a[3] | b[3]) ^ op[1]`. The block counts mismatches and reports the first failing vector, so it sits opposite the ALU and closes the loop for gate-level and post-layout flow checks.

## Interface
Parameters:
- `SETTLE`, default 1: cycles between driving a vector and sampling its result; legal range is 1..15.
- `STOP_ON_FAIL`, default 0: when 1, the sweep ends at the first mismatch.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- `dut_a`  out  4  ALU operand a, registered.
- `dut_b`  out  4  ALU operand b, registered.
- `dut_op`  out  2  ALU opcode, registered.
- `dut_y`  in  4  ALU result under test.
- `dut_cout`  in  1  ALU carry/flag output under test.
- `busy`  out  1  high while a sweep is running.
- `done`  out  1  high from sweep end until the next accepted start or reset.
- `pass`  out  1  equals `done & (err_count == 0)`.
- `err_count`  out  11  number of mismatching vectors in the current or last sweep (0..1024).
- `fail_seen`  out  1  at least one mismatch in the current or last sweep.
- `fail_vec`  out  10  index of the first mismatching vector; valid when `fail_seen`.

## Operation
- Vector index `idx[9:0]` maps to operands as follows: `dut_a = idx[3:0]`, `dut_b = idx[7:4]`, `dut_op = idx[9:8]`.
- Vectors are swept in ascending order, 0 to 1023.
- The FSM has three states: IDLE, RUN and DONE.
- IDLE or DONE, on `start`:
  - `idx` goes to 0 and vector 0 is driven.
  - `err_count`, `fail_seen`, `fail_vec` and `done` are cleared.
  - `busy` goes to 1, the settle counter goes to 0, and the state moves to RUN.
- RUN: the settle counter increments each cycle. On the edge where it equals `SETTLE-1`, the block samples:
  - It computes the expected values from the currently driven `dut_a`, `dut_b`, `dut_op`.
  - A mismatch is any bit differing on `dut_y` or on `dut_cout`. It is one error per vector, not per bit.
  - On mismatch, `err_count` increments. If `fail_seen` was 0, the block also sets `fail_seen` and sets `fail_vec = idx`.
  - If `idx == 1023`, or `STOP_ON_FAIL = 1` and this sample mismatched: the state moves to DONE, `busy` goes to 0, `done` goes to 1, and `dut_*` hold the last driven vector.
  - Otherwise `idx` increments, the next vector is driven on the same edge, and the settle counter goes to 0.
- `start` asserted during RUN is ignored; the sweep is not restarted.
- DONE holds all results stable until `start` or `rst`.
- `err_count` cannot overflow because its maximum value is 1024, which fits in 11 bits.

## Timing
- Reset (async, immediate) drives these values:
  - `dut_a = 0`, `dut_b = 0`, `dut_op = 0`
  - `busy = 0`, `done = 0`, `pass = 0`
  - `err_count = 0`, `fail_seen = 0`, `fail_vec = 0`
  - state returns to IDLE.
- A reset mid-sweep abandons the sweep with no partial results retained.
- Let E_s be the edge on which `start` is accepted:
  - Vector k is driven after edge E_s + k·SETTLE.
  - Vector k is sampled at edge E_s + (k+1)·SETTLE.
- A full sweep gives `done = 1` after edge E_s + 1024·SETTLE, i.e. 1024 cycles at `SETTLE = 1`.
- With `STOP_ON_FAIL = 1`, `done` rises after the edge sampling the first failing vector.
- `pass` is combinational from registered state; it adds no extra latency.
- `dut_y` and `dut_cout` must be stable SETTLE cycles after the operands change; no input synchronisation is performed.

## Test plan
- Clean sweep: behavioural ALU, `SETTLE = 1`, pulse `start`.
  - Required: `busy` high for exactly 1024 cycles, then `done = 1`, `pass = 1`, `err_count = 0`, `fail_seen = 0`.
- Stuck-at-0 fault on `y[2]`, `STOP_ON_FAIL = 0`.
  - Required: `err_count = 512`, `fail_seen = 1`, `fail_vec = 68` (0x044), `pass = 0`.
- Same stuck-at-0 fault on `y[2]`, `STOP_ON_FAIL = 1`.
  - Required: `done` after edge E_s + 69, `err_count = 1`, `fail_vec = 68`.
  - Required: `dut_a = 4`, `dut_b = 4`, `dut_op = 0` held.
- Inverted `cout`.
  - Required: `err_count = 1024`, `fail_vec = 0`.
- `SETTLE = 3` with the ALU output registered by one cycle.
  - Required: `pass = 1` after 3072 cycles.
  - Same DUT with `SETTLE = 1`: required `pass = 0`.
- Control events:
  - `start` pulsed at idx 300: ignored, and the sweep completes normally.
  - `rst` asserted at idx 500: all outputs return to reset values immediately.
  - A new `start` after that reset yields a clean full sweep.
  - `start` in DONE: clears the results and reruns the sweep.
